sim_halt_monitor: RTL and testbench
===================================

# sim_halt_monitor

Parametrised, synthesizable end-of-simulation monitor for the `riscv_cpu` bench top. It detects halting conditions on the retire stream:
- `ebreak`, and optionally `ecall`;
- illegal encodings;
- a no-retire watchdog timeout.

On detection it holds the core, drains for a configurable number of cycles, then latches exit code, cause, PC and performance counters. The bench top makes its DPI trap call on `halt_pulse` only; no DPI lives inside this block.

## Interface
Reset is synchronous and active-high on `rst`, sampled on the rising edge of `clk`. The design has one clock.

Parameters:
- `XLEN`, 32: datapath width of `pc`, `a0`, `exit_code` and `halt_pc`.
- `CNT_W`, 64: width of the cycle, instret and watchdog counters.
- `TIMEOUT`, 1000000: number of consecutive no-retire cycles that triggers a halt. 0 disables the watchdog.
- `DRAIN`, 2: number of cycles between detection and halt. 0 is legal.
- `ECALL_HALT`, 0: when 1, `ecall` also halts.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `inst_valid`  in  1  instruction retires this cycle.
- `inst`  in  32  retiring instruction.
- `pc`  in  XLEN  PC of the retiring instruction.
- `a0`  in  XLEN  current value of x10.
- `cpu_hold`  out  1  freeze request to the core (no fetch, no commit).
- `halt`  out  1  sticky halted flag.
- `halt_pulse`  out  1  single-cycle strobe on entry to HALT.
- `halt_cause`  out  3  0 none, 1 ebreak, 2 ecall, 3 illegal, 4 timeout.
- `exit_code`  out  XLEN  program exit value.
- `halt_pc`  out  XLEN  PC of the halting event.
- `cycle_cnt`  out  CNT_W  cycles spent in RUN.
- `instret_cnt`  out  CNT_W  instructions retired in RUN.

## Operation
The FSM has three states: RUN, DRAIN and HALT.

**Reset.** Reset enters RUN and clears every output, counter and capture register to 0. Reset wins over all other events, in any state.

**RUN: counters.**
- `cycle_cnt` increments by 1 every cycle.
- `instret_cnt` increments when `inst_valid` is high. This includes the halting instruction.
- The watchdog count is cleared on `inst_valid` and incremented otherwise.
- All counters wrap modulo 2^CNT_W and never saturate.

**RUN: detection.** Detection is evaluated only when `inst_valid` is high, unless noted:
- ebreak: `inst == 32'h00100073` → cause 1, `exit_code=a0`.
- ecall: `inst == 32'h00000073` and `ECALL_HALT=1` → cause 2, `exit_code=a0`. With `ECALL_HALT=0`, ecall is a normal instruction.
- illegal: `inst == 0`, or `inst == 32'hFFFFFFFF`, or `inst[1:0] != 2'b11` → cause 3, `exit_code` all ones.
- timeout: requires `TIMEOUT != 0`. Fires when `inst_valid` is low and the watchdog count equals `TIMEOUT-1` → cause 4, `exit_code` all ones.
- Priority: instruction-based causes beat timeout. A retire clears the watchdog, so the two cannot coincide.
- `halt_pc` captures `pc` at detection in every case, including timeout.

**On detection.**
- Cause, exit code and PC are captured.
- Counters freeze; the detecting cycle is counted.
- Next state is DRAIN, or HALT directly if `DRAIN=0`.

**DRAIN.**
- `cpu_hold=1`.
- `inst_valid` is ignored.
- A drain counter runs for `DRAIN` cycles, then the FSM moves to HALT.

**HALT.**
- `cpu_hold=1` and `halt=1`.
- `halt_pulse=1` in the first HALT cycle only.
- All outputs are stable until reset.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- If detection happens at edge k:
  - `cpu_hold` is high from cycle k+1.
  - The core therefore commits nothing at edge k+1 or later.
  - `halt` and `halt_pulse` rise at edge k+1+DRAIN.
- `halt_cause`, `exit_code` and `halt_pc` are valid from edge k+1. They are guaranteed only while `halt=1`.
- Timeout with `TIMEOUT=T`: after the last retire, T idle cycles produce detection at the T-th idle edge.
- Reset asserted during DRAIN or HALT: RUN and all-zero outputs at the next edge; `halt_pulse` is not emitted.
- A second trap instruction presented while in DRAIN or HALT has no effect.

## Structure
- Package `sim_pkg` holds:
  - the `halt_cause_e` enum (3 bits);
  - the `state_e` enum (RUN, DRAIN, HALT);
  - the constants `INST_EBREAK`, `INST_ECALL` and `EXIT_ERR` (all ones).
- One sub-module is natural: `sim_counter`, a parametrised CNT_W counter with enable, clear and synchronous reset.
  - It is instantiated three times: cycle, instret, watchdog.
- The drain counter is a `$clog2(DRAIN+1)`-bit register local to the FSM.

## Test plan
1. **ebreak exit.** Reset 2 cycles, retire 5 `addi` with a0=7, then ebreak at pc=0x80000014 → `cpu_hold` high one cycle later; with DRAIN=2, `halt_pulse` 3 cycles after the ebreak edge, cause=1, exit_code=7, halt_pc=0x80000014, instret_cnt=6.
2. **ecall mode.** ecall with ECALL_HALT=0 → no halt, instret increments. Repeat with ECALL_HALT=1 → cause=2, exit_code=a0.
3. **Illegal.** Retire `inst=0` → cause=3, exit_code=0xFFFFFFFF. Repeat with `inst=32'h00000013` → no halt.
4. **Watchdog.** TIMEOUT=10, retire one instruction then hold `inst_valid` low → detection on the 10th idle edge, cause=4. A retire at idle cycle 9 restarts the count.
5. **DRAIN=0 and reset mid-DRAIN.** DRAIN=0: `halt` at k+1. DRAIN=4, assert `rst` in the second DRAIN cycle → all outputs 0 and no `halt_pulse`; a new ebreak then halts normally.
6. **Wrap and post-halt stability.** CNT_W=4, retire 17 instructions → instret_cnt=1 before the trap. A trap instruction presented during HALT changes nothing over 20 cycles.

Source files
------------

// File: rtl/sim_pkg.sv
// Shared types and constants for the end-of-simulation halt monitor.
package sim_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_EBREAK  = 3'd1,
    CAUSE_ECALL   = 3'd2,
    CAUSE_ILLEGAL = 3'd3,
    CAUSE_TIMEOUT = 3'd4
  } halt_cause_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  // Sliced down to XLEN at the point of use.
  localparam logic [63:0] EXIT_ERR    = '1;

endpackage

// File: rtl/sim_counter.sv
// Free-running wrap-around counter with enable, clear and synchronous reset.
module sim_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear beats enable so the watchdog restarts from zero on a retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sim_halt_monitor.sv
// End-of-simulation monitor: detects ebreak/ecall/illegal/watchdog halts on the
// retire stream, holds the core, drains, then latches exit status.
module sim_halt_monitor
  import sim_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 64,
  parameter int TIMEOUT    = 1000000,
  parameter int DRAIN      = 2,
  parameter int ECALL_HALT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  a0,
  output logic             cpu_hold,
  output logic             halt,
  output logic             halt_pulse,
  output logic [2:0]       halt_cause,
  output logic [XLEN-1:0]  exit_code,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam bit              WDOG_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam int              DW         = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = (DRAIN > 0) ? DW'(DRAIN - 1) : '0;

  state_e            state;
  logic [DW-1:0]     drain_cnt;
  logic [CNT_W-1:0]  wdog_cnt;
  halt_cause_e       cause_d;
  logic [XLEN-1:0]   exit_d;
  logic              detect;
  logic              in_run;

  assign in_run = (state == S_RUN);

  sim_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .en    (in_run),
    .clr   (1'b0),
    .count (cycle_cnt)
  );

  sim_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .en    (in_run && inst_valid),
    .clr   (1'b0),
    .count (instret_cnt)
  );

  sim_counter #(.W(CNT_W)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .en    (in_run && !inst_valid),
    .clr   (in_run && inst_valid),
    .count (wdog_cnt)
  );

  // A retire clears the watchdog, so instruction causes and timeout never coincide.
  always_comb begin
    cause_d = CAUSE_NONE;
    exit_d  = a0;
    if (inst_valid) begin
      if (inst == INST_EBREAK) begin
        cause_d = CAUSE_EBREAK;
      end else if ((ECALL_HALT != 0) && (inst == INST_ECALL)) begin
        cause_d = CAUSE_ECALL;
      end else if ((inst == '0) || (inst == '1) || (inst[1:0] != 2'b11)) begin
        cause_d = CAUSE_ILLEGAL;
        exit_d  = EXIT_ERR[XLEN-1:0];
      end
    end else if (WDOG_EN && (wdog_cnt == WDOG_LAST)) begin
      cause_d = CAUSE_TIMEOUT;
      exit_d  = EXIT_ERR[XLEN-1:0];
    end
  end

  assign detect = (cause_d != CAUSE_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      drain_cnt  <= '0;
      cpu_hold   <= 1'b0;
      halt_cause <= '0;
      exit_code  <= '0;
      halt_pc    <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (detect) begin
            halt_cause <= cause_d;
            exit_code  <= exit_d;
            halt_pc    <= pc;
            cpu_hold   <= 1'b1;
            drain_cnt  <= '0;
            state      <= (DRAIN == 0) ? S_HALT : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_HALT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Halt flags trail the HALT state by one register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt       <= 1'b0;
      halt_pulse <= 1'b0;
    end else begin
      halt       <= (state == S_HALT);
      halt_pulse <= (state == S_HALT) && !halt;
    end
  end

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Directed bench for sim_halt_monitor across three parameter sets sharing one stimulus.
module tb_sim_halt_monitor;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] ADDI   = 32'h0070_0513;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] a0;

  int checks   = 0;
  int failures = 0;

  // dut_a: watchdog 10, drain 2, ecall not halting
  logic        a_hold, a_halt, a_pulse;
  logic [2:0]  a_cause;
  logic [31:0] a_exit, a_hpc;
  logic [63:0] a_cycle, a_instret;

  // dut_b: no watchdog, drain 0, ecall halts, 4-bit counters
  logic        b_hold, b_halt, b_pulse;
  logic [2:0]  b_cause;
  logic [31:0] b_exit, b_hpc;
  logic [3:0]  b_cycle, b_instret;

  // dut_c: no watchdog, drain 4
  logic        c_hold, c_halt, c_pulse;
  logic [2:0]  c_cause;
  logic [31:0] c_exit, c_hpc;
  logic [63:0] c_cycle, c_instret;

  always #5 clk = ~clk;

  sim_halt_monitor #(.XLEN(32), .CNT_W(64), .TIMEOUT(10), .DRAIN(2), .ECALL_HALT(0)) dut_a (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
    .cpu_hold(a_hold), .halt(a_halt), .halt_pulse(a_pulse), .halt_cause(a_cause),
    .exit_code(a_exit), .halt_pc(a_hpc), .cycle_cnt(a_cycle), .instret_cnt(a_instret)
  );

  sim_halt_monitor #(.XLEN(32), .CNT_W(4), .TIMEOUT(0), .DRAIN(0), .ECALL_HALT(1)) dut_b (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
    .cpu_hold(b_hold), .halt(b_halt), .halt_pulse(b_pulse), .halt_cause(b_cause),
    .exit_code(b_exit), .halt_pc(b_hpc), .cycle_cnt(b_cycle), .instret_cnt(b_instret)
  );

  sim_halt_monitor #(.XLEN(32), .CNT_W(64), .TIMEOUT(0), .DRAIN(4), .ECALL_HALT(0)) dut_c (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
    .cpu_hold(c_hold), .halt(c_halt), .halt_pulse(c_pulse), .halt_cause(c_cause),
    .exit_code(c_exit), .halt_pc(c_hpc), .cycle_cnt(c_cycle), .instret_cnt(c_instret)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] i,
                               input logic [31:0] p, input logic [31:0] a);
    inst_valid = v;
    inst       = i;
    pc         = p;
    a0         = a;
    tick();
  endtask

  task automatic resetAll();
    rst = 1'b1;
    applyStimulus(1'b0, NOP, 32'h0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst       = NOP;
    pc         = '0;
    a0         = '0;
    tick();
    tick();
    checkOutput("rst_hold",    64'(a_hold), 64'd0);
    checkOutput("rst_halt",    64'(a_halt), 64'd0);
    checkOutput("rst_pulse",   64'(a_pulse), 64'd0);
    checkOutput("rst_cause",   64'(a_cause), 64'd0);
    checkOutput("rst_exit",    64'(a_exit), 64'd0);
    checkOutput("rst_cycle",   a_cycle, 64'd0);
    checkOutput("rst_instret", a_instret, 64'd0);
    rst = 1'b0;

    // ebreak exit with DRAIN=2
    $display("[TB] ebreak exit");
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, ADDI, 32'h8000_0000 + 32'(4 * n), 32'd7);
    applyStimulus(1'b1, EBREAK, 32'h8000_0014, 32'd7);
    checkOutput("eb_hold_k",    64'(a_hold), 64'd1);
    checkOutput("eb_halt_k",    64'(a_halt), 64'd0);
    checkOutput("eb_cause",     64'(a_cause), 64'd1);
    checkOutput("eb_exit",      64'(a_exit), 64'd7);
    checkOutput("eb_pc",        64'(a_hpc), 64'h8000_0014);
    checkOutput("eb_instret",   a_instret, 64'd6);
    applyStimulus(1'b1, ADDI, 32'h8000_0018, 32'd9);
    checkOutput("eb_halt_k1",   64'(a_halt), 64'd0);
    applyStimulus(1'b0, NOP, 32'h0, 32'd9);
    checkOutput("eb_halt_k2",   64'(a_halt), 64'd0);
    checkOutput("eb_pulse_k2",  64'(a_pulse), 64'd0);
    applyStimulus(1'b0, NOP, 32'h0, 32'd9);
    checkOutput("eb_halt_k3",   64'(a_halt), 64'd1);
    checkOutput("eb_pulse_k3",  64'(a_pulse), 64'd1);
    applyStimulus(1'b0, NOP, 32'h0, 32'd9);
    checkOutput("eb_pulse_k4",  64'(a_pulse), 64'd0);
    checkOutput("eb_halt_k4",   64'(a_halt), 64'd1);
    checkOutput("eb_cycle_frz", a_cycle, 64'd6);
    checkOutput("eb_instr_frz", a_instret, 64'd6);
    checkOutput("eb_exit_frz",  64'(a_exit), 64'd7);

    // ecall: ignored by dut_a, halts dut_b with DRAIN=0
    $display("[TB] ecall mode and DRAIN=0");
    resetAll();
    checkOutput("rst_from_halt", 64'(a_halt), 64'd0);
    applyStimulus(1'b1, ECALL, 32'h0000_0200, 32'd5);
    checkOutput("ec0_hold",     64'(a_hold), 64'd0);
    checkOutput("ec0_instret",  a_instret, 64'd1);
    checkOutput("ec1_hold",     64'(b_hold), 64'd1);
    checkOutput("ec1_cause",    64'(b_cause), 64'd2);
    checkOutput("ec1_exit",     64'(b_exit), 64'd5);
    checkOutput("ec1_halt_k",   64'(b_halt), 64'd0);
    applyStimulus(1'b0, NOP, 32'h0, 32'd0);
    checkOutput("d0_halt_k1",   64'(b_halt), 64'd1);
    checkOutput("d0_pulse_k1",  64'(b_pulse), 64'd1);
    checkOutput("ec0_halt",     64'(a_halt), 64'd0);
    applyStimulus(1'b0, NOP, 32'h0, 32'd0);
    checkOutput("d0_pulse_k2",  64'(b_pulse), 64'd0);

    // illegal encodings
    $display("[TB] illegal");
    resetAll();
    applyStimulus(1'b1, NOP, 32'h0000_0300, 32'd9);
    checkOutput("nop_hold",     64'(a_hold), 64'd0);
    applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0304, 32'd9);
    checkOutput("ill_hold",     64'(a_hold), 64'd1);
    checkOutput("ill_cause",    64'(a_cause), 64'd3);
    checkOutput("ill_exit",     64'(a_exit), 64'hFFFF_FFFF);
    checkOutput("ill_pc",       64'(a_hpc), 64'h304);
    checkOutput("ill_instret",  a_instret, 64'd2);
    resetAll();
    applyStimulus(1'b1, 32'h0000_0012, 32'h0000_0308, 32'd9);
    checkOutput("ill_low2",     64'(a_cause), 64'd3);

    // watchdog TIMEOUT=10, restarted by a retire after 9 idle cycles
    $display("[TB] watchdog");
    resetAll();
    applyStimulus(1'b1, ADDI, 32'h0000_0400, 32'd1);
    for (int n = 0; n < 9; n++) applyStimulus(1'b0, NOP, 32'h0000_0404, 32'd1);
    checkOutput("wd_idle9",     64'(a_hold), 64'd0);
    applyStimulus(1'b1, ADDI, 32'h0000_0404, 32'd1);
    checkOutput("wd_restart",   64'(a_hold), 64'd0);
    for (int n = 0; n < 9; n++) applyStimulus(1'b0, NOP, 32'h0000_0408, 32'd1);
    checkOutput("wd_idle9b",    64'(a_hold), 64'd0);
    applyStimulus(1'b0, NOP, 32'h0000_0408, 32'd1);
    checkOutput("wd_hold",      64'(a_hold), 64'd1);
    checkOutput("wd_cause",     64'(a_cause), 64'd4);
    checkOutput("wd_exit",      64'(a_exit), 64'hFFFF_FFFF);
    checkOutput("wd_pc",        64'(a_hpc), 64'h408);
    checkOutput("wd_instret",   a_instret, 64'd2);
    checkOutput("wd_cycle",     a_cycle, 64'd21);

    // reset in the second DRAIN cycle of dut_c
    $display("[TB] reset mid-drain");
    resetAll();
    applyStimulus(1'b1, EBREAK, 32'h0000_0500, 32'd3);
    checkOutput("md_hold",      64'(c_hold), 64'd1);
    applyStimulus(1'b0, NOP, 32'h0, 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, NOP, 32'h0, 32'd0);
    rst = 1'b0;
    checkOutput("md_rst_hold",  64'(c_hold), 64'd0);
    checkOutput("md_rst_cause", 64'(c_cause), 64'd0);
    checkOutput("md_rst_exit",  64'(c_exit), 64'd0);
    checkOutput("md_rst_pc",    64'(c_hpc), 64'd0);
    checkOutput("md_rst_cnt",   c_cycle, 64'd0);
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1'b1, ADDI, 32'h0000_0510, 32'd0);
      checkOutput("md_no_pulse", 64'(c_pulse), 64'd0);
    end
    checkOutput("md_no_halt",   64'(c_halt), 64'd0);
    checkOutput("md_instret",   c_instret, 64'd6);
    applyStimulus(1'b1, EBREAK, 32'h0000_0600, 32'd11);
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, NOP, 32'h0, 32'd0);
    checkOutput("md_halt_k4",   64'(c_halt), 64'd0);
    applyStimulus(1'b0, NOP, 32'h0, 32'd0);
    checkOutput("md_halt_k5",   64'(c_halt), 64'd1);
    checkOutput("md_pulse_k5",  64'(c_pulse), 64'd1);
    checkOutput("md_exit",      64'(c_exit), 64'd11);
    checkOutput("md_pc",        64'(c_hpc), 64'h600);

    // 4-bit counter wrap and stability while halted
    $display("[TB] wrap and post-halt stability");
    resetAll();
    for (int n = 0; n < 17; n++) applyStimulus(1'b1, ADDI, 32'h0000_0700, 32'h42);
    checkOutput("wr_instret",   64'(b_instret), 64'd1);
    checkOutput("wr_cycle",     64'(b_cycle), 64'd1);
    applyStimulus(1'b1, EBREAK, 32'h0000_0744, 32'h42);
    applyStimulus(1'b0, NOP, 32'h0, 32'd0);
    checkOutput("wr_halt",      64'(b_halt), 64'd1);
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, (n % 3 == 0) ? ECALL : ((n % 3 == 1) ? EBREAK : 32'h0),
                    32'h0000_0900 + 32'(n), 32'h1000 + 32'(n));
      checkOutput("st_halt",    64'(b_halt), 64'd1);
      checkOutput("st_pulse",   64'(b_pulse), 64'd0);
      checkOutput("st_cause",   64'(b_cause), 64'd1);
      checkOutput("st_exit",    64'(b_exit), 64'h42);
      checkOutput("st_pc",      64'(b_hpc), 64'h744);
      checkOutput("st_instret", 64'(b_instret), 64'd2);
      checkOutput("st_cycle",   64'(b_cycle), 64'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
